// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the bus master and slave units.
// One-hot slave handshake states plus bus widths.
package wb_pkg;

  localparam int DATA_W   = 32;
  localparam int SEL_W    = DATA_W / 8;
  localparam int WB_ADR_W = 32;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_WAIT = 4'b0010,
    S_RESP = 4'b0100,
    S_HOLD = 4'b1000
  } wb_state_t;

endpackage

// File: rtl/wb_ram_array.sv
// Single-port synchronous word RAM with byte-lane write enables.
// Read data is registered; contents are never reset.
module wb_ram_array
  import wb_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MEM_WORDS = 1024
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [SEL_W-1:0]  be_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [DATA_W-1:0] wdat_i,
  output logic [DATA_W-1:0] rdat_o
);

  logic [DATA_W-1:0] mem_q [MEM_WORDS];
  logic [DATA_W-1:0] rdat_q;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < SEL_W; i++) begin
      if (we_i && be_i[i]) begin
        mem_q[adr_i][8*i +: 8] <= wdat_i[8*i +: 8];
      end
    end
    rdat_q <= mem_q[adr_i];
  end

  assign rdat_o = rdat_q;

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone B4 classic slave in front of a byte-lane word RAM.
// Programmable wait states, error on bad address, HOLD guards stb tail.
module wb_ram_slave
  import wb_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [WB_ADR_W-1:0] wbs_adr_i,
  input  logic [SEL_W-1:0]    wbs_sel_i,
  input  logic [DATA_W-1:0]   wbs_dat_i,
  output logic [DATA_W-1:0]   wbs_dat_o,
  output logic                wbs_ack_o,
  output logic                wbs_err_o
);

  wb_state_t         state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              bad_q, bad_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;

  logic              req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_adr;
  logic [DATA_W-1:0] ram_rdat;

  function automatic logic adr_bad(
    input logic [WB_ADR_W-1:0] a
  );
    logic [ADDR_W:0] idx;
    idx = {1'b0, a[ADDR_W+1:2]};
    return (a[1:0] != 2'b00)
        || (a[WB_ADR_W-1:ADDR_W+2] != '0)
        || (idx >= (ADDR_W+1)'(MEM_WORDS));
  endfunction

  assign req = wbs_cyc_i & wbs_stb_i;

  // In IDLE the RAM reads the live address so data is ready even with zero waits
  assign ram_adr = (state_q == S_IDLE)
                 ? wbs_adr_i[ADDR_W+1:2]
                 : adr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    bad_d   = bad_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    dat_d   = dat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    ram_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = wbs_we_i;
          bad_d   = adr_bad(wbs_adr_i);
          adr_d   = wbs_adr_i[ADDR_W+1:2];
          sel_d   = wbs_sel_i;
          wdat_d  = wbs_dat_i;
          cnt_d   = 4'(WAIT_STATES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          if (bad_q) begin
            err_d = 1'b1;
            dat_d = '0;
          end else begin
            ack_d  = 1'b1;
            ram_we = we_q & rst_i;
            if (!we_q) begin
              dat_d = ram_rdat;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!wbs_stb_i || !wbs_cyc_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    we_q   <= we_d;
    bad_q  <= bad_d;
    adr_q  <= adr_d;
    sel_q  <= sel_d;
    wdat_q <= wdat_d;
  end

  wb_ram_array #(
    .ADDR_W   (ADDR_W),
    .MEM_WORDS(MEM_WORDS)
  ) u_ram (
    .clk_i (clk_i),
    .we_i  (ram_we),
    .be_i  (sel_q),
    .adr_i (ram_adr),
    .wdat_i(wdat_q),
    .rdat_o(ram_rdat)
  );

  assign wbs_dat_o = dat_q;
  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Bench for wb_ram_slave: one instance with 1 wait state, one with 3.
// A word-array memory model predicts ack/err timing, read data and dat_o holding.
module tb_wb_ram_slave;

  localparam int WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cyc [2];
  logic        stb [2];
  logic        we_i;
  logic [31:0] adr_i;
  logic [3:0]  sel_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o [2];
  logic        ack_o [2];
  logic        err_o [2];

  int checks = 0;
  int errors = 0;

  int          ws [2];
  logic [31:0] mem_m [2][WORDS];
  bit          known [2][WORDS];
  logic [31:0] exp_dat [2];
  logic [31:0] obs;

  always #5 clk = ~clk;

  wb_ram_slave #(.ADDR_W(10), .MEM_WORDS(WORDS), .WAIT_STATES(1)) dut_a (
    .clk_i(clk), .rst_i(rst_i),
    .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we_i),
    .wbs_adr_i(adr_i), .wbs_sel_i(sel_i), .wbs_dat_i(dat_i),
    .wbs_dat_o(dat_o[0]), .wbs_ack_o(ack_o[0]), .wbs_err_o(err_o[0])
  );

  wb_ram_slave #(.ADDR_W(10), .MEM_WORDS(WORDS), .WAIT_STATES(3)) dut_b (
    .clk_i(clk), .rst_i(rst_i),
    .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we_i),
    .wbs_adr_i(adr_i), .wbs_sel_i(sel_i), .wbs_dat_i(dat_i),
    .wbs_dat_o(dat_o[1]), .wbs_ack_o(ack_o[1]), .wbs_err_o(err_o[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= WORDS);
  endfunction

  task automatic quiet(input int w, input string tag);
    chk(tag, {30'd0, ack_o[w], err_o[w]}, 32'd0);
  endtask

  task automatic txn(input int w, input bit we, input logic [31:0] adr,
                     input logic [3:0] sel, input logic [31:0] d,
                     input int hold, output logic [31:0] rd);
    int  lat;
    int  word;
    bit  bad;
    lat  = ws[w] + 2;
    bad  = is_bad(adr);
    word = int'(adr / 4);
    cyc[w] = 1'b1; stb[w] = 1'b1;
    we_i = we; adr_i = adr; sel_i = sel; dat_i = d;
    for (int n = 1; n < lat; n++) begin
      tick();
      quiet(w, "wait_quiet");
      we_i  = 1'($urandom);
      adr_i = $urandom;
      sel_i = 4'($urandom);
      dat_i = $urandom;
    end
    tick();
    rd = dat_o[w];
    if (bad) begin
      chk("err_resp", {30'd0, ack_o[w], err_o[w]}, 32'd1);
      exp_dat[w] = '0;
    end else begin
      chk("ack_resp", {30'd0, ack_o[w], err_o[w]}, 32'd2);
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (sel[i]) mem_m[w][word][8*i +: 8] = d[8*i +: 8];
        if (sel == 4'hF) known[w][word] = 1'b1;
      end else begin
        exp_dat[w] = mem_m[w][word];
      end
    end
    chk("resp_dat", dat_o[w], exp_dat[w]);
    for (int h = 0; h < hold; h++) begin
      tick();
      quiet(w, "hold_quiet");
    end
    cyc[w] = 1'b0; stb[w] = 1'b0;
    tick();
    quiet(w, "tail_quiet");
    tick();
    chk("dat_keep", dat_o[w], exp_dat[w]);
  endtask

  task automatic abort_txn(input int w, input logic [31:0] adr,
                           input logic [31:0] d, input int after);
    cyc[w] = 1'b1; stb[w] = 1'b1;
    we_i = 1'b1; adr_i = adr; sel_i = 4'hF; dat_i = d;
    for (int n = 0; n < after; n++) begin
      tick();
      quiet(w, "abort_wait");
    end
    cyc[w] = 1'b0; stb[w] = 1'b0;
    for (int n = 0; n < ws[w] + 3; n++) begin
      tick();
      quiet(w, "abort_quiet");
    end
  endtask

  initial begin
    ws[0] = 1;
    ws[1] = 3;
    exp_dat[0] = '0;
    exp_dat[1] = '0;
    rst_i = 1'b0;
    cyc[0] = 1'b0; stb[0] = 1'b0;
    cyc[1] = 1'b0; stb[1] = 1'b0;
    we_i = 1'b0; adr_i = '0; sel_i = '0; dat_i = '0;
    tick();
    tick();
    for (int w = 0; w < 2; w++) begin
      quiet(w, "reset_quiet");
      chk("reset_dat", dat_o[w], 32'd0);
    end
    rst_i = 1'b1;
    tick();

    txn(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1, obs);
    txn(0, 1'b0, 32'h10, 4'hF, 32'h0, 1, obs);
    chk("rd_deadbeef", obs, 32'hDEADBEEF);
    txn(0, 1'b1, 32'h10, 4'b0010, 32'h0000AA00, 1, obs);
    txn(0, 1'b0, 32'h10, 4'h0, 32'h0, 1, obs);
    chk("rd_lane1", obs, 32'hDEADAAEF);

    txn(0, 1'b0, 32'h1000, 4'hF, 32'h0, 1, obs);
    txn(0, 1'b0, 32'h13, 4'hF, 32'h0, 1, obs);
    txn(0, 1'b1, 32'h8000_0010, 4'hF, 32'hFFFFFFFF, 1, obs);
    txn(0, 1'b1, 32'h11, 4'hF, 32'h01010101, 1, obs);
    txn(0, 1'b1, 32'h10, 4'h0, 32'h11111111, 1, obs);
    txn(0, 1'b0, 32'h10, 4'hF, 32'h0, 3, obs);
    chk("word4_kept", obs, 32'hDEADAAEF);
    txn(0, 1'b1, 32'hFFC, 4'hF, 32'h600DCAFE, 0, obs);
    txn(0, 1'b0, 32'hFFC, 4'hF, 32'h0, 0, obs);
    chk("last_word", obs, 32'h600DCAFE);

    txn(1, 1'b1, 32'h20, 4'hF, 32'h0BADF00D, 1, obs);
    abort_txn(1, 32'h20, 32'h12345678, 2);
    txn(1, 1'b0, 32'h20, 4'hF, 32'h0, 1, obs);
    chk("abort_keep", obs, 32'h0BADF00D);

    cyc[1] = 1'b1; stb[1] = 1'b1;
    we_i = 1'b1; adr_i = 32'h20; sel_i = 4'hF; dat_i = 32'hCAFEF00D;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    exp_dat[0] = '0;
    exp_dat[1] = '0;
    for (int w = 0; w < 2; w++) begin
      quiet(w, "midrst_quiet");
      chk("midrst_dat", dat_o[w], 32'd0);
    end
    rst_i = 1'b1;
    cyc[1] = 1'b0; stb[1] = 1'b0;
    tick();
    txn(1, 1'b0, 32'h20, 4'hF, 32'h0, 1, obs);
    chk("midrst_keep", obs, 32'h0BADF00D);

    for (int k = 0; k < 80; k++) begin
      int          w;
      int          op;
      int          word;
      logic [31:0] a;
      w    = int'($urandom_range(0, 1));
      op   = int'($urandom_range(0, 3));
      word = int'($urandom_range(0, WORDS - 1));
      if (op == 3) begin
        if ($urandom_range(0, 1) == 0)
          a = word * 4 + $urandom_range(1, 3);
        else
          a = ($urandom | 32'h1000) & 32'hFFFF_FFFC;
        txn(w, 1'($urandom), a, 4'hF, $urandom,
            int'($urandom_range(0, 2)), obs);
      end else if (op == 0 || !known[w][word]) begin
        txn(w, 1'b1, word * 4, 4'hF, $urandom,
            int'($urandom_range(0, 2)), obs);
      end else if (op == 1) begin
        txn(w, 1'b1, word * 4, 4'($urandom), $urandom,
            int'($urandom_range(0, 2)), obs);
      end else begin
        txn(w, 1'b0, word * 4, 4'($urandom), $urandom,
            int'($urandom_range(0, 2)), obs);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
